ctrl_pipe_seq: RTL and testbench

- Second-generation MIPS control unit. Decodes the D-stage instruction and carries the control bundle through registered X/M/W stages.
- Adds stall/flush bubble insertion, a multi-cycle MULT sequencer, and parametrised branch modes (BEQ, optionally BNE).
- Sits between the IF/ID register and the datapath. The datapath consumes the per-stage control outputs directly.

---
 rtl/ctrl_pipe_seq_if.sv | 42 ++++
 rtl/ctrl_pipe_seq.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_ctrl_pipe_seq.sv | 277 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ctrl_pipe_seq_if.sv
// ctrl_pipe_seq_if: decode-side bus between the IF/ID register, the hazard
// unit, the datapath and the ctrl_pipe_seq control unit.
//   master : the side driving instructions/hazards (datapath, IF/ID, bench)
//   slave  : the control unit
// Signals
//   instr_D, valid_D      instruction in D and its valid flag
//   stall_in, flush_in    external load-use stall / external flush of D
//   zero_X                ALU zero flag for the instruction in X
//   ctrl_X                12-bit control bundle in X
//   regwrite_M, memwrite_M, memread_M, regwrite_W, memtoreg_W  late-stage controls
//   jump_D, stall_D, br_taken_X, flush_D  decode/hazard results
interface ctrl_pipe_seq_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] instr_D;
  logic              valid_D;
  logic              stall_in;
  logic              flush_in;
  logic              zero_X;
  logic [11:0]       ctrl_X;
  logic              regwrite_M;
  logic              memwrite_M;
  logic              memread_M;
  logic              regwrite_W;
  logic              memtoreg_W;
  logic              jump_D;
  logic              stall_D;
  logic              br_taken_X;
  logic              flush_D;

  modport master (
    output instr_D, valid_D, stall_in, flush_in, zero_X,
    input  ctrl_X, regwrite_M, memwrite_M, memread_M, regwrite_W, memtoreg_W,
    input  jump_D, stall_D, br_taken_X, flush_D
  );

  modport slave (
    input  instr_D, valid_D, stall_in, flush_in, zero_X,
    output ctrl_X, regwrite_M, memwrite_M, memread_M, regwrite_W, memtoreg_W,
    output jump_D, stall_D, br_taken_X, flush_D
  );
endinterface

// File: rtl/ctrl_pipe_seq.sv
// mips_pkg: opcode/funct/ALU encodings, per-stage mnemonic type and the
// control bundle layout shared by the control unit and its users.
//
// ctrl_pipe_seq: MIPS control unit. Decodes the D-stage instruction and
// carries the control bundle through registered X/M/W stages, inserting
// bubbles on stall/flush and holding MULT in X for MULT_LAT cycles.
// Ports
//   clk, rst           clock, synchronous active-high reset
//   bus (slave)        decode inputs and per-stage control outputs
//   pnem_D/X/M/W       mnemonic of the instruction in each stage
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_ABS   = 6'h1c;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_MULT = 6'h18;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SLT  = 6'h2a;

  // Shifts share one ALU code; the shifter picks SLL/SRL/SRA from funct[1:0].
  localparam logic [2:0] ALU_AND   = 3'd0;
  localparam logic [2:0] ALU_OR    = 3'd1;
  localparam logic [2:0] ALU_ADD   = 3'd2;
  localparam logic [2:0] ALU_XOR   = 3'd3;
  localparam logic [2:0] ALU_SHIFT = 3'd4;
  localparam logic [2:0] ALU_ABS   = 3'd5;
  localparam logic [2:0] ALU_SUB   = 3'd6;
  localparam logic [2:0] ALU_SLT   = 3'd7;

  typedef enum logic [4:0] {
    NEM_ZERO, NEM_ADD, NEM_SUB, NEM_AND, NEM_OR, NEM_XOR, NEM_SLT,
    NEM_SLL, NEM_SRL, NEM_SRA, NEM_MULT, NEM_ADDI, NEM_ADDIU,
    NEM_LW, NEM_SW, NEM_BEQ, NEM_BNE, NEM_J, NEM_ABS
  } t_instr_pnmen;

  typedef struct packed {
    logic       jump;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src;
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       branch;
    logic       br_ne;
    logic [2:0] alu_ctl;
  } ctrl_t;
endpackage

module ctrl_pipe_seq
  import mips_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int MULT_LAT = 4,
  parameter int BR_MODE  = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  ctrl_pipe_seq_if.slave        bus,
  output t_instr_pnmen          pnem_D,
  output t_instr_pnmen          pnem_X,
  output t_instr_pnmen          pnem_M,
  output t_instr_pnmen          pnem_W
);
  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
  } m_ctrl_t;

  typedef struct packed {
    logic reg_write;
    logic mem_to_reg;
  } w_ctrl_t;

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  // Countdown start so that MULT sits in X for exactly MULT_LAT cycles
  // (entry cycle + MULT_LAT-1 BUSY cycles ending at cnt==0).
  localparam logic [3:0] CNT_INIT = (MULT_LAT > 1) ? 4'(MULT_LAT - 2) : 4'd0;

  logic [5:0]   opcode, funct;
  logic         unused_instr;
  ctrl_t        dec;
  t_instr_pnmen nem_d;

  ctrl_t        x_q;
  m_ctrl_t      m_q;
  w_ctrl_t      w_q;
  t_instr_pnmen nem_x_q, nem_m_q, nem_w_q;

  state_t       state_q, state_n;
  logic [3:0]   cnt_q, cnt_n;
  logic         mult_entry, hold_x;
  logic         br_taken, flush_d;

  assign opcode       = bus.instr_D[DATA_W-1 -: 6];
  assign funct        = bus.instr_D[5:0];
  assign unused_instr = ^bus.instr_D[DATA_W-7:6];

  // ---------------------------------------------------------------- decode
  always_comb begin
    dec   = '0;
    nem_d = NEM_ZERO;
    if (bus.valid_D && (bus.instr_D != '0)) begin
      case (opcode)
        OP_RTYPE: begin
          dec.reg_dst   = 1'b1;
          dec.reg_write = 1'b1;
          case (funct)
            F_ADD:  begin dec.alu_ctl = ALU_ADD;   nem_d = NEM_ADD;  end
            F_SUB:  begin dec.alu_ctl = ALU_SUB;   nem_d = NEM_SUB;  end
            F_AND:  begin dec.alu_ctl = ALU_AND;   nem_d = NEM_AND;  end
            F_OR:   begin dec.alu_ctl = ALU_OR;    nem_d = NEM_OR;   end
            F_XOR:  begin dec.alu_ctl = ALU_XOR;   nem_d = NEM_XOR;  end
            F_SLT:  begin dec.alu_ctl = ALU_SLT;   nem_d = NEM_SLT;  end
            F_SLL:  begin dec.alu_ctl = ALU_SHIFT; nem_d = NEM_SLL;  end
            F_SRL:  begin dec.alu_ctl = ALU_SHIFT; nem_d = NEM_SRL;  end
            F_SRA:  begin dec.alu_ctl = ALU_SHIFT; nem_d = NEM_SRA;  end
            // Multiplier reads operands directly; alu_ctl left at zero.
            F_MULT: begin                          nem_d = NEM_MULT; end
            default: dec = '0;
          endcase
        end
        OP_ADDI, OP_ADDIU: begin
          dec.alu_src   = 1'b1;
          dec.reg_write = 1'b1;
          dec.alu_ctl   = ALU_ADD;
          nem_d         = (opcode == OP_ADDI) ? NEM_ADDI : NEM_ADDIU;
        end
        OP_LW: begin
          dec.alu_src    = 1'b1;
          dec.mem_read   = 1'b1;
          dec.mem_to_reg = 1'b1;
          dec.reg_write  = 1'b1;
          dec.alu_ctl    = ALU_ADD;
          nem_d          = NEM_LW;
        end
        OP_SW: begin
          dec.alu_src   = 1'b1;
          dec.mem_write = 1'b1;
          dec.alu_ctl   = ALU_ADD;
          nem_d         = NEM_SW;
        end
        OP_BEQ: begin
          dec.branch  = 1'b1;
          dec.alu_ctl = ALU_SUB;
          nem_d       = NEM_BEQ;
        end
        OP_BNE: begin
          if (BR_MODE == 1) begin
            dec.branch  = 1'b1;
            dec.br_ne   = 1'b1;
            dec.alu_ctl = ALU_SUB;
            nem_d       = NEM_BNE;
          end
        end
        OP_J: begin
          dec.jump = 1'b1;
          nem_d    = NEM_J;
        end
        OP_ABS: begin
          dec.reg_write = 1'b1;
          dec.alu_ctl   = ALU_ABS;
          nem_d         = NEM_ABS;
        end
        default: ;
      endcase
    end
  end

  // --------------------------------------------------------------- MULT FSM
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
    end
  end

  // hold_x covers every MULT cycle except the last, so the final BUSY
  // cycle (cnt==0) lets MULT move to M and the held D instruction into X.
  always_comb begin
    state_n    = state_q;
    cnt_n      = cnt_q;
    mult_entry = 1'b0;
    hold_x     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if ((nem_x_q == NEM_MULT) && (MULT_LAT > 1)) begin
          mult_entry = 1'b1;
          hold_x     = 1'b1;
          state_n    = S_BUSY;
          cnt_n      = CNT_INIT;
        end
      end
      S_BUSY: begin
        if (cnt_q == 4'd0) begin
          state_n = S_IDLE;
        end else begin
          hold_x = 1'b1;
          cnt_n  = cnt_q - 4'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------- branch/hazard
  assign br_taken = x_q.branch & (x_q.br_ne ? ~bus.zero_X : bus.zero_X);
  assign flush_d  = br_taken | bus.flush_in;

  // ---------------------------------------------------------- stage regs
  always_ff @(posedge clk) begin
    if (rst) begin
      x_q     <= '0;
      nem_x_q <= NEM_ZERO;
      m_q     <= '0;
      nem_m_q <= NEM_ZERO;
      w_q     <= '0;
      nem_w_q <= NEM_ZERO;
    end else begin
      // D->X: MULT hold, then flush/stall bubble, then normal advance.
      if (hold_x) begin
        x_q     <= x_q;
        nem_x_q <= nem_x_q;
      end else if (flush_d || bus.stall_in) begin
        x_q     <= '0;
        nem_x_q <= NEM_ZERO;
      end else begin
        x_q     <= dec;
        nem_x_q <= nem_d;
      end

      if (hold_x) begin
        m_q     <= '0;
        nem_m_q <= NEM_ZERO;
      end else begin
        m_q     <= '{x_q.reg_write, x_q.mem_write, x_q.mem_read, x_q.mem_to_reg};
        nem_m_q <= nem_x_q;
      end

      w_q     <= '{m_q.reg_write, m_q.mem_to_reg};
      nem_w_q <= nem_m_q;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign bus.ctrl_X     = x_q;
  assign bus.regwrite_M = m_q.reg_write;
  assign bus.memwrite_M = m_q.mem_write;
  assign bus.memread_M  = m_q.mem_read;
  assign bus.regwrite_W = w_q.reg_write;
  assign bus.memtoreg_W = w_q.mem_to_reg;
  assign bus.jump_D     = dec.jump;
  assign bus.stall_D    = bus.stall_in | (state_q == S_BUSY) | mult_entry;
  assign bus.br_taken_X = br_taken;
  assign bus.flush_D    = flush_d;

  assign pnem_D = nem_d;
  assign pnem_X = nem_x_q;
  assign pnem_M = nem_m_q;
  assign pnem_W = nem_w_q;
endmodule

// File: tb/tb_ctrl_pipe_seq.sv
// Bench for ctrl_pipe_seq. dut0: BR_MODE=0, MULT_LAT=4 (main, scoreboarded
// at W). dut1: BR_MODE=1, MULT_LAT=1, fed the same inputs, spot-checked for
// BNE decode and the no-stall single-cycle MULT.
module tb_ctrl_pipe_seq;
  import mips_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ctrl_pipe_seq_if #(.DATA_W(32)) bus0 ();
  ctrl_pipe_seq_if #(.DATA_W(32)) bus1 ();

  t_instr_pnmen p0_D, p0_X, p0_M, p0_W;
  t_instr_pnmen p1_D, p1_X, p1_M, p1_W;

  ctrl_pipe_seq #(.DATA_W(32), .MULT_LAT(4), .BR_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0),
    .pnem_D(p0_D), .pnem_X(p0_X), .pnem_M(p0_M), .pnem_W(p0_W)
  );

  ctrl_pipe_seq #(.DATA_W(32), .MULT_LAT(1), .BR_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1),
    .pnem_D(p1_D), .pnem_X(p1_X), .pnem_M(p1_M), .pnem_W(p1_W)
  );

  typedef struct {
    t_instr_pnmen nem;
    logic         rw;
    logic         mtr;
  } sb_t;

  typedef struct {
    logic [31:0]  ins;
    t_instr_pnmen nem;
    logic [11:0]  ctl;
    logic         rw;
    logic         mtr;
  } dec_t;

  sb_t  sb[$];
  dec_t tbl[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [5:0] fn);
    return {6'h00, 5'd1, 5'd2, 5'd3, 5'd0, fn};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op);
    return {op, 5'd1, 5'd2, 16'h0010};
  endfunction

  task automatic set_in(input logic [31:0] ins, input logic v, input logic st,
                        input logic fl, input logic z);
    bus0.instr_D = ins; bus0.valid_D = v; bus0.stall_in = st; bus0.flush_in = fl; bus0.zero_X = z;
    bus1.instr_D = ins; bus1.valid_D = v; bus1.stall_in = st; bus1.flush_in = fl; bus1.zero_X = z;
  endtask

  task automatic push(input t_instr_pnmen n, input logic rw, input logic mtr);
    sb_t e;
    e.nem = n; e.rw = rw; e.mtr = mtr;
    sb.push_back(e);
  endtask

  task automatic add_tbl(input logic [31:0] ins, input t_instr_pnmen n, input logic [11:0] ctl,
                         input logic rw, input logic mtr);
    dec_t d;
    d.ins = ins; d.nem = n; d.ctl = ctl; d.rw = rw; d.mtr = mtr;
    tbl.push_back(d);
  endtask

  // Advance one cycle; any real instruction retiring in W is checked
  // against the oldest expected entry.
  task automatic tick();
    sb_t e;
    @(posedge clk);
    #1;
    if (p0_W != NEM_ZERO) begin
      if (sb.size() == 0) begin
        chk("sb_unexpected", 32'(p0_W), 32'(NEM_ZERO));
      end else begin
        e = sb.pop_front();
        chk("sb_nem", 32'(p0_W), 32'(e.nem));
        chk("sb_regwrite_W", 32'(bus0.regwrite_W), 32'(e.rw));
        chk("sb_memtoreg_W", 32'(bus0.memtoreg_W), 32'(e.mtr));
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] prev_ctl;
    rst = 1'b1;
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    // Reset state
    chk("rst_ctrl_X", 32'(bus0.ctrl_X), 32'h0);
    chk("rst_regwrite_M", 32'(bus0.regwrite_M), 32'h0);
    chk("rst_regwrite_W", 32'(bus0.regwrite_W), 32'h0);
    chk("rst_stall_D", 32'(bus0.stall_D), 32'h0);
    chk("rst_flush_D", 32'(bus0.flush_D), 32'h0);
    chk("rst_pnem_X", 32'(p0_X), 32'(NEM_ZERO));
    chk("rst_pnem_W", 32'(p0_W), 32'(NEM_ZERO));

    // ADD through the pipe
    set_in(rtype(F_ADD), 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("add_pnem_D", 32'(p0_D), 32'(NEM_ADD));
    push(NEM_ADD, 1'b1, 1'b0);
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("add_ctrl_X", 32'(bus0.ctrl_X), 32'h602);
    chk("add_pnem_X", 32'(p0_X), 32'(NEM_ADD));
    chk("invalid_pnem_D", 32'(p0_D), 32'(NEM_ZERO));
    tick();
    chk("add_pnem_M", 32'(p0_M), 32'(NEM_ADD));
    chk("add_regwrite_M", 32'(bus0.regwrite_M), 32'h1);
    tick();
    chk("add_regwrite_W", 32'(bus0.regwrite_W), 32'h1);
    tick();

    // Decode table, back to back
    add_tbl(itype(OP_ADDI),  NEM_ADDI,  12'h302, 1'b1, 1'b0);
    add_tbl(itype(OP_ADDIU), NEM_ADDIU, 12'h302, 1'b1, 1'b0);
    add_tbl(itype(OP_SW),    NEM_SW,    12'h182, 1'b0, 1'b0);
    add_tbl(itype(OP_LW),    NEM_LW,    12'h362, 1'b1, 1'b1);
    add_tbl({OP_J, 26'h10},  NEM_J,     12'h800, 1'b0, 1'b0);
    add_tbl(itype(OP_ABS),   NEM_ABS,   12'h205, 1'b1, 1'b0);
    add_tbl(rtype(F_SUB),    NEM_SUB,   12'h606, 1'b1, 1'b0);
    add_tbl(rtype(F_XOR),    NEM_XOR,   12'h603, 1'b1, 1'b0);
    add_tbl(rtype(F_SLL),    NEM_SLL,   12'h604, 1'b1, 1'b0);
    add_tbl(rtype(F_SRA),    NEM_SRA,   12'h604, 1'b1, 1'b0);
    add_tbl(rtype(6'h3f),    NEM_ZERO,  12'h000, 1'b0, 1'b0);
    add_tbl(itype(6'h3f),    NEM_ZERO,  12'h000, 1'b0, 1'b0);
    prev_ctl = 12'h000;
    for (int i = 0; i < tbl.size(); i++) begin
      set_in(tbl[i].ins, 1'b1, 1'b0, 1'b0, 1'b0); #1;
      chk("tbl_pnem_D", 32'(p0_D), 32'(tbl[i].nem));
      chk("tbl_jump_D", 32'(bus0.jump_D), 32'(tbl[i].ctl[11]));
      if (tbl[i].nem != NEM_ZERO) push(tbl[i].nem, tbl[i].rw, tbl[i].mtr);
      tick();
      chk("tbl_ctrl_X", 32'(bus0.ctrl_X), 32'(tbl[i].ctl));
      chk("tbl_pnem_X", 32'(p0_X), 32'(tbl[i].nem));
      chk("tbl_memwrite_M", 32'(bus0.memwrite_M), 32'(prev_ctl[7]));
      chk("tbl_memread_M", 32'(bus0.memread_M), 32'(prev_ctl[6]));
      prev_ctl = tbl[i].ctl;
    end
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // MULT (4 cycles in X) then ADD
    set_in(rtype(F_MULT), 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("mult_pre_stall", 32'(bus0.stall_D), 32'h0);
    push(NEM_MULT, 1'b1, 1'b0);
    tick();
    set_in(rtype(F_ADD), 1'b1, 1'b0, 1'b0, 1'b0); #1;
    push(NEM_ADD, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) begin
      chk("mult_stall_D", 32'(bus0.stall_D), 32'h1);
      chk("mult_pnem_X", 32'(p0_X), 32'(NEM_MULT));
      chk("mult_ctrl_X", 32'(bus0.ctrl_X), 32'h600);
      chk("mult_pnem_M", 32'(p0_M), 32'(NEM_ZERO));
      if (k == 0) chk("lat1_stall_D", 32'(bus1.stall_D), 32'h0);
      if (k == 1) chk("lat1_pnem_M", 32'(p1_M), 32'(NEM_MULT));
      tick();
    end
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("mult_done_stall", 32'(bus0.stall_D), 32'h0);
    chk("mult_add_pnem_X", 32'(p0_X), 32'(NEM_ADD));
    chk("mult_pnem_M_out", 32'(p0_M), 32'(NEM_MULT));
    repeat (3) tick();

    // BEQ taken: D instruction killed
    set_in(itype(OP_BEQ), 1'b1, 1'b0, 1'b0, 1'b0); #1;
    push(NEM_BEQ, 1'b0, 1'b0);
    tick();
    set_in(itype(OP_LW), 1'b1, 1'b0, 1'b0, 1'b1); #1;
    chk("beq_ctrl_X", 32'(bus0.ctrl_X), 32'h016);
    chk("beq_taken", 32'(bus0.br_taken_X), 32'h1);
    chk("beq_flush_D", 32'(bus0.flush_D), 32'h1);
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    chk("beq_kill_pnem_X", 32'(p0_X), 32'(NEM_ZERO));
    chk("bubble_no_taken", 32'(bus0.br_taken_X), 32'h0);
    // BEQ not taken: next instruction proceeds
    set_in(itype(OP_BEQ), 1'b1, 1'b0, 1'b0, 1'b0); #1;
    push(NEM_BEQ, 1'b0, 1'b0);
    tick();
    set_in(rtype(F_ADD), 1'b1, 1'b0, 1'b0, 1'b0); #1;
    push(NEM_ADD, 1'b1, 1'b0);
    chk("beqnt_taken", 32'(bus0.br_taken_X), 32'h0);
    chk("beqnt_flush_D", 32'(bus0.flush_D), 32'h0);
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("beqnt_pnem_X", 32'(p0_X), 32'(NEM_ADD));
    repeat (3) tick();

    // stall_in + flush_in on LW: flush wins, then stall alone, then release
    set_in(itype(OP_LW), 1'b1, 1'b1, 1'b1, 1'b0); #1;
    chk("sf_flush_D", 32'(bus0.flush_D), 32'h1);
    chk("sf_stall_D", 32'(bus0.stall_D), 32'h1);
    tick();
    chk("sf_pnem_X", 32'(p0_X), 32'(NEM_ZERO));
    set_in(itype(OP_SW), 1'b1, 1'b1, 1'b0, 1'b0); #1;
    chk("st_flush_D", 32'(bus0.flush_D), 32'h0);
    tick();
    chk("st_pnem_X", 32'(p0_X), 32'(NEM_ZERO));
    set_in(itype(OP_SW), 1'b1, 1'b0, 1'b0, 1'b0); #1;
    push(NEM_SW, 1'b0, 1'b0);
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("st_release_pnem_X", 32'(p0_X), 32'(NEM_SW));
    tick();
    chk("sw_memwrite_M", 32'(bus0.memwrite_M), 32'h1);
    repeat (2) tick();

    // BNE: unknown with BR_MODE=0, taken on zero_X=0 with BR_MODE=1
    set_in(itype(OP_BNE), 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("bne_m0_pnem_D", 32'(p0_D), 32'(NEM_ZERO));
    chk("bne_m1_pnem_D", 32'(p1_D), 32'(NEM_BNE));
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("bne_m1_taken", 32'(bus1.br_taken_X), 32'h1);
    chk("bne_m1_flush", 32'(bus1.flush_D), 32'h1);
    chk("bne_m1_brbits", 32'(bus1.ctrl_X[4:3]), 32'h3);
    chk("bne_m0_taken", 32'(bus0.br_taken_X), 32'h0);
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b1); #1;
    chk("bne_m1_zero_nt", 32'(bus1.br_taken_X), 32'h0);
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    repeat (3) tick();

    // Reset two cycles into a MULT
    set_in(rtype(F_MULT), 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    set_in(rtype(F_ADD), 1'b1, 1'b0, 1'b0, 1'b0); #1;
    chk("rm_stall_entry", 32'(bus0.stall_D), 32'h1);
    tick();
    chk("rm_stall_busy", 32'(bus0.stall_D), 32'h1);
    rst = 1'b1;
    sb.delete();
    tick();
    rst = 1'b0;
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("rm_stall_D", 32'(bus0.stall_D), 32'h0);
    chk("rm_ctrl_X", 32'(bus0.ctrl_X), 32'h0);
    chk("rm_pnem_X", 32'(p0_X), 32'(NEM_ZERO));
    chk("rm_pnem_M", 32'(p0_M), 32'(NEM_ZERO));
    chk("rm_pnem_W", 32'(p0_W), 32'(NEM_ZERO));
    set_in(rtype(F_ADD), 1'b1, 1'b0, 1'b0, 1'b0); #1;
    push(NEM_ADD, 1'b1, 1'b0);
    tick();
    set_in(32'h0, 1'b0, 1'b0, 1'b0, 1'b0); #1;
    chk("rm_add_pnem_X", 32'(p0_X), 32'(NEM_ADD));
    chk("rm_add_stall", 32'(bus0.stall_D), 32'h0);
    repeat (4) tick();

    chk("sb_drain", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
